// File: rtl/rs232_rx_byte_pkg.sv
// -----------------------------------------------------------------------------
// rs232_rx_byte_pkg
// Shared constants and the receiver state encoding for the RS-232 byte
// receiver. No ports; imported by rs232_rx_byte.
// -----------------------------------------------------------------------------
package rs232_rx_byte_pkg;

  // System clock and line rate that the default bit period is derived from.
  localparam int CLK_HZ               = 50_000_000;
  localparam int BAUD_RATE            = 115_200;
  localparam int DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD_RATE;  // 434

  // Receiver states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/rs232_rx_byte_sync_2ff.sv
// -----------------------------------------------------------------------------
// rs232_rx_byte_sync_2ff
// Two-flop synchronizer for a single asynchronous input bit. Both stages
// reset to RESET_VAL so an idle-high line does not look like activity
// straight out of reset.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset
//   d      : asynchronous input
//   q      : synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module rs232_rx_byte_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/rs232_rx_byte.sv
// -----------------------------------------------------------------------------
// rs232_rx_byte
// UART 8N1 receive front end. Oversamples iRXD, samples each bit at its
// middle, and presents each good byte with a one-cycle oVALID pulse. A low
// stop bit gives a one-cycle oFRAME_ERR pulse, discards the byte and waits
// for the line to return high before hunting for the next start bit.
//   iCLK       : system clock (50 MHz), rising edge
//   iNRST      : asynchronous active-low reset
//   iRXD       : serial line, idle high, asynchronous
//   oDATA      : last correctly received byte, LSB = first data bit
//   oVALID     : one-cycle pulse, oDATA updated this cycle
//   oFRAME_ERR : one-cycle pulse, stop bit sampled low
//   oBUSY      : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module rs232_rx_byte
  import rs232_rx_byte_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       iCLK,
  input  logic       iNRST,
  input  logic       iRXD,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oFRAME_ERR,
  output logic       oBUSY
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  // Count reached in START when we are at the middle of the start bit.
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  rx_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic [7:0]       shift_r;
  logic [7:0]       data_r;
  logic             valid_r;
  logic             ferr_r;
  logic             busy_r;

  rs232_rx_byte_sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_rxd (
    .clk   (iCLK),
    .rst_n (iNRST),
    .d     (iRXD),
    .q     (rx_s)
  );

  // Receiver FSM with bit timing, shift register and registered outputs.
  always_ff @(posedge iCLK or negedge iNRST) begin
    if (!iNRST) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!rx_s) begin
            state_r <= ST_START;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
          end
        end

        ST_START: begin
          if (cnt_r != HALF_CNT) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else if (!rx_s) begin
            // Still low at mid start bit: a real frame.
            state_r <= ST_DATA;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= 3'd0;
          end else begin
            // Line back high before mid start bit: treat as a glitch.
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
          end
        end

        ST_DATA: begin
          if (cnt_r != LAST_CNT) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r   <= {CNT_W{1'b0}};
            // LSB arrives first, so shift right and insert at the MSB.
            shift_r <= {rx_s, shift_r[7:1]};
            if (idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end

        ST_STOP: begin
          if (cnt_r != LAST_CNT) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= {CNT_W{1'b0}};
            if (rx_s) begin
              data_r  <= shift_r;
              valid_r <= 1'b1;
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              ferr_r  <= 1'b1;
              state_r <= ST_WAIT_HIGH;
            end
          end
        end

        // A held-low line (break) must not decode as repeated 0x00 bytes.
        ST_WAIT_HIGH: begin
          if (rx_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign oDATA      = data_r;
  assign oVALID     = valid_r;
  assign oFRAME_ERR = ferr_r;
  assign oBUSY      = busy_r;

endmodule

// File: doc/rs232_rx_byte.md
# rs232_rx_byte

UART receive front end: oversamples the host serial line (iRXD, driven from the USB bridge TXD pin), recovers 8N1 bytes with a mid-bit sampling state machine, and presents each byte as a one-cycle-valid word. It sits directly upstream of RS232_CONTROL, which consumes the byte stream and decodes commands for SEQ_WAVE_GEN. Runs in the 50 MHz CLK_50 domain; the line itself is asynchronous.

## Interface
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); legal range ≥ 4
- iCLK  input  1  system clock, 50 MHz, all logic on rising edge
- iNRST  input  1  asynchronous, active-low reset
- iRXD  input  1  serial line, idle high, asynchronous to iCLK
- oDATA  output  8  last correctly received byte, LSB = first data bit
- oVALID  output  1  one-cycle pulse: oDATA updated this cycle
- oFRAME_ERR  output  1  one-cycle pulse: stop bit sampled low, byte discarded
- oBUSY  output  1  high in any state other than IDLE

## Operation
- iRXD passes through 2-FF synchronizer; both stages reset to 1. Output rx_s drives all logic.
- HALF = (CLKS_PER_BIT-1)/2 (integer). Bit counter: $clog2(CLKS_PER_BIT) bits. Data index: 3 bits. Shift register: 8 bits, shifts right, MSB-in.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: rx_s=0 -> START, cnt<=0.
- START: cnt!=HALF -> cnt++. cnt==HALF: rx_s=0 -> DATA, cnt<=0, idx<=0; rx_s=1 -> IDLE (glitch rejected, no output).
- DATA: cnt!=CLKS_PER_BIT-1 -> cnt++. Else sample rx_s into shift reg, cnt<=0; idx==7 -> STOP, else idx++.
- STOP: count as DATA. At sample: rx_s=1 -> oDATA<=shift, oVALID<=1, IDLE; rx_s=0 -> oFRAME_ERR<=1, oDATA unchanged, WAIT_HIGH.
- WAIT_HIGH: stays until rx_s=1, then IDLE. Prevents a break condition from being decoded as a stream of 0x00.
- oVALID, oFRAME_ERR never both high. Each is high for exactly one cycle per frame.
- Reset values: oDATA=8'h00, oVALID=0, oFRAME_ERR=0, oBUSY=0, state=IDLE, counters 0, shift reg 0.
- No back-pressure: the consumer must accept oDATA on the oVALID cycle. oDATA holds until the next good byte.

## Timing
- E0 = first iCLK edge that captures iRXD=0 into sync stage 1. rx_s is low after E1. IDLE->START at E2.
- Start sample at E(3+HALF). Data bit k sample at E(3+HALF+(k+1)·CLKS_PER_BIT). Stop sample at E(3+HALF+9·CLKS_PER_BIT).
- oVALID/oFRAME_ERR are registered: high in the cycle following the stop-sample edge. Default: stop sample at E4125.
- Back-to-back frames: a new start edge is accepted from IDLE immediately after the stop sample. Consecutive oVALID pulses are spaced exactly 10·CLKS_PER_BIT cycles when the sender has no idle gap and there is zero drift.
- Sampling is mid-bit, so the block tolerates about ±4% baud mismatch over 10 bits.
- iNRST low at any point, including mid-frame: all state returns to reset values asynchronously, with no pulse emitted. After release, the first falling edge seen in IDLE starts a frame. A frame already in progress at release is decoded from its next low bit, which may produce a frame error; this is accepted.

## Structure
- Shared header para.h holds: state encodings, default CLKS_PER_BIT, and the 50 MHz clock constant.
- One sub-module, sync_2ff (1-bit, reset value parameter), reused for the trigger input elsewhere.
- FSM, counters, and shift register sit in this module. The estimate is about 150 lines.

## Test plan
- 0xA5 at 434 clk/bit, one stop bit -> single oVALID at E4125+1, oDATA=0xA5, oFRAME_ERR stays 0.
- 0x00 then 0xFF with no idle gap -> two oVALID pulses 4340 cycles apart, oDATA 0x00 then 0xFF.
- iRXD low for 100 cycles then high -> START aborts at HALF sample, no pulse, oBUSY drops, oDATA unchanged.
- Frame 0x3C with stop bit 0, line held low 20 bit-times, then a good 0x81 -> one oFRAME_ERR, oDATA stays previous value, no further pulses during the low period, then oVALID with 0x81.
- Assert iNRST during bit 4 of 0x55 -> outputs return to reset values immediately. A subsequent clean 0x55 decodes correctly.
- Sender at 3% fast and at 3% slow baud, bytes 0xC3 and 0x18 -> both decoded correctly.
